xncn_accum_recip: RTL and testbench

- Upstream feeder for the 1/N scaling multiplier stage of the OCR feature path.
- Accumulates sample-times-coefficient products Xn·Cn over one frame of N samples.
- Produces the saturated 16-bit sum XnCn and the 17-bit reciprocal 1/N (unsigned, 16 fractional bits, 65536/N) through a sequential restoring divider.
- Presents both values to the downstream multiplier with a valid/ready handshake.

---
 rtl/xncn_accum_recip_if.sv | 37 +++
 rtl/xncn_accum_recip.sv | 186 ++++++++++++++++++
 tb/tb_xncn_accum_recip.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/xncn_accum_recip_if.sv
// ---------------------------------------------------------------------------
// xncn_accum_recip_if
// Handshake bundle between the Xn*Cn accumulator / 1/N generator and its
// neighbours.
//   Upstream side   : in_valid, in_ready, in_x, in_c, in_last
//   Downstream side : out_valid, out_ready, xncn, onebyn, sat, frame_ovf
// Modports:
//   slave  - the xncn_accum_recip block itself
//   master - the environment driving pairs and consuming results
// Parameters: XW sample width, CW coefficient width.
// ---------------------------------------------------------------------------
interface xncn_accum_recip_if #(
    parameter int XW = 8,
    parameter int CW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [XW-1:0] in_x;
    logic [CW-1:0] in_c;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   xncn;
    logic [16:0]   onebyn;
    logic          sat;
    logic          frame_ovf;

    modport slave (
        input  in_valid, in_x, in_c, in_last, out_ready,
        output in_ready, out_valid, xncn, onebyn, sat, frame_ovf
    );

    modport master (
        output in_valid, in_x, in_c, in_last, out_ready,
        input  in_ready, out_valid, xncn, onebyn, sat, frame_ovf
    );
endinterface

// File: rtl/xncn_accum_recip.sv
// ---------------------------------------------------------------------------
// xncn_accum_recip
// Feeder for the 1/N scaling multiplier of the OCR feature path. Accumulates
// Xn*Cn over one frame of N pairs, then produces the saturated 16-bit sum and
// the reciprocal 1/N (17 bits, 16 fractional bits) using a sequential
// restoring divider, and offers both downstream with valid/ready.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - synchronous active-low reset
//   bus    - xncn_accum_recip_if.slave:
//              in_valid/in_ready/in_x/in_c/in_last  pair input
//              out_valid/out_ready                  result handshake
//              xncn      saturated frame sum
//              onebyn    reciprocal of the frame length
//              sat       sum exceeded 16'hFFFF
//              frame_ovf frame closed at the counter limit
//
// Build option:
//   ROUND_RECIP_EN - when defined, onebyn is rounded to nearest (ties up)
//                    instead of truncated.
//
// Timing: the result appears 18 edges after the edge accepting the closing
// pair (17 quotient-bit iterations plus one edge to publish the result).
// ---------------------------------------------------------------------------
module xncn_accum_recip #(
    parameter int XW = 8,
    parameter int CW = 8,
    parameter int NW = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    xncn_accum_recip_if.slave  bus
);

    localparam int AW = XW + CW + NW;   // wide enough that the sum never wraps
    localparam int DW = 17;             // dividend / quotient width

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DIV   = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state;
    logic [AW-1:0]   acc;
    logic [NW-1:0]   count;
    logic [NW-1:0]   n_lat;
    logic [NW-1:0]   rem;
    logic [DW-1:0]   dvd;
    logic [DW-1:0]   quo;
    logic [4:0]      step;
    logic [15:0]     xncn_div;
    logic            sat_div;
    logic            ovf_div;

    logic            in_ready_r;
    logic            out_valid_r;
    logic [15:0]     xncn_r;
    logic [16:0]     onebyn_r;
    logic            sat_r;
    logic            ovf_r;

    logic            accept;
    logic [AW-1:0]   prod;
    logic [AW-1:0]   acc_sum;
    logic [NW-1:0]   cnt_inc;
    logic            close;
    logic [DW-1:0]   dvd_init;
    logic [NW:0]     rem_sh;
    logic [NW:0]     rem_sub;
    logic            q_bit;

    function automatic logic [15:0] sat16(input logic [AW-1:0] a);
        return (a > AW'(16'hFFFF)) ? 16'hFFFF : a[15:0];
    endfunction

    function automatic logic [16:0] clamp_recip(input logic [DW-1:0] q);
        return (q > 17'h10000) ? 17'h10000 : q;
    endfunction

    assign accept  = bus.in_valid & in_ready_r;
    assign prod    = AW'(bus.in_x) * AW'(bus.in_c);
    assign acc_sum = acc + prod;
    assign cnt_inc = count + 1'b1;
    // Frame closes on in_last or when the counter hits its all-ones limit.
    assign close   = bus.in_last | (cnt_inc == {NW{1'b1}});

    // 65536 + floor(N/2) stays below 2^17 for any N < 2^NW (NW <= 16), so
    // both variants share the same 17-iteration divider.
`ifdef ROUND_RECIP_EN
    assign dvd_init = 17'h10000 + DW'(cnt_inc >> 1);
`else
    assign dvd_init = 17'h10000;
`endif

    // One restoring step. rem < N, so the shifted partial remainder fits
    // NW+1 bits and the top bit of the difference is the borrow.
    assign rem_sh  = {rem, dvd[DW-1]};
    assign rem_sub = rem_sh - {1'b0, n_lat};
    assign q_bit   = ~rem_sub[NW];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ACCUM;
            acc         <= '0;
            count       <= '0;
            n_lat       <= '0;
            rem         <= '0;
            dvd         <= '0;
            quo         <= '0;
            step        <= '0;
            xncn_div    <= '0;
            sat_div     <= 1'b0;
            ovf_div     <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            xncn_r      <= '0;
            onebyn_r    <= '0;
            sat_r       <= 1'b0;
            ovf_r       <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        acc   <= acc_sum;
                        count <= cnt_inc;
                        if (close) begin
                            state      <= DIV;
                            in_ready_r <= 1'b0;
                            n_lat      <= cnt_inc;
                            xncn_div   <= sat16(acc_sum);
                            sat_div    <= (acc_sum > AW'(16'hFFFF));
                            ovf_div    <= ~bus.in_last;
                            rem        <= '0;
                            dvd        <= dvd_init;
                            quo        <= '0;
                            step       <= '0;
                        end
                    end
                end

                // ---- divider: steps 0..16 iterate, step 17 publishes ----
                DIV: begin
                    if (step == 5'(DW)) begin
                        state       <= HOLD;
                        out_valid_r <= 1'b1;
                        xncn_r      <= xncn_div;
                        onebyn_r    <= clamp_recip(quo);
                        sat_r       <= sat_div;
                        ovf_r       <= ovf_div;
                    end else begin
                        rem  <= q_bit ? rem_sub[NW-1:0] : rem_sh[NW-1:0];
                        dvd  <= {dvd[DW-2:0], 1'b0};
                        quo  <= {quo[DW-2:0], q_bit};
                        step <= step + 1'b1;
                    end
                end

                HOLD: begin
                    if (bus.out_ready) begin
                        state       <= ACCUM;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        acc         <= '0;
                        count       <= '0;
                    end
                end

                default: begin
                    state       <= ACCUM;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.xncn      = xncn_r;
    assign bus.onebyn    = onebyn_r;
    assign bus.sat       = sat_r;
    assign bus.frame_ovf = ovf_r;

endmodule

// File: tb/tb_xncn_accum_recip.sv
// ---------------------------------------------------------------------------
// tb_xncn_accum_recip
// Scoreboard bench: the stimulus process computes each frame's expected
// result from plain arithmetic and queues it; a monitor pops and compares
// whenever a result handshake occurs, and also checks output latency.
// ---------------------------------------------------------------------------
module tb_xncn_accum_recip;

    localparam int XW = 8;
    localparam int CW = 8;
    localparam int NW = 10;

    typedef struct packed {
        logic [15:0] xncn;
        logic [16:0] onebyn;
        logic        sat;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    xncn_accum_recip_if #(.XW(XW), .CW(CW)) bus ();

    xncn_accum_recip #(.XW(XW), .CW(CW), .NW(NW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last_acc = 0;
    bit   prev_ov = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Reference: sum saturated to 16 bits, reciprocal 65536/N.
    function automatic exp_t model(input longint sum, input int n, input bit ovf);
        exp_t e;
        longint r;
        e.xncn = (sum > 65535) ? 16'hFFFF : 16'(sum);
        e.sat  = (sum > 65535);
`ifdef ROUND_RECIP_EN
        r = (65536 + n / 2) / n;
        if (r > 65536) r = 65536;
`else
        r = 65536 / n;
`endif
        e.onebyn = 17'(r);
        e.ovf    = ovf;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: latency on rising out_valid, scoreboard compare on handshake.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) last_acc = cyc + 1;
            if (bus.out_valid && !prev_ov)
                chk("latency", 64'(cyc - last_acc), 64'd18);
            if (bus.out_valid && bus.out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_out", 64'(bus.out_valid), 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("xncn",      64'(bus.xncn),      64'(e.xncn));
                    chk("onebyn",    64'(bus.onebyn),    64'(e.onebyn));
                    chk("sat",       64'(bus.sat),       64'(e.sat));
                    chk("frame_ovf", 64'(bus.frame_ovf), 64'(e.ovf));
                end
            end
        end
        prev_ov = bus.out_valid;
    end

    // Entered and left at posedge+1.
    task automatic send_pair(input logic [7:0] x, input logic [7:0] c, input bit last);
        int g;
        g = 0;
        bus.in_valid = 1'b1;
        bus.in_x     = x;
        bus.in_c     = c;
        bus.in_last  = last;
        @(negedge clk);
        while (!bus.in_ready && g < 100) begin
            g++;
            @(negedge clk);
        end
        if (!bus.in_ready) chk("accept_timeout", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // xv/cv < 0 selects random values; gaps inserts idle cycles carrying a
    // stray in_last with in_valid low.
    task automatic run_frame(input int n, input int xv, input int cv,
                             input bit use_last, input bit gaps, input bit push);
        longint sum;
        logic [7:0] x;
        logic [7:0] c;
        sum = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.in_last = 1'b1;
                @(posedge clk);
                #1;
                bus.in_last = 1'b0;
            end
            x = (xv < 0) ? 8'($urandom_range(0, 255)) : 8'(xv);
            c = (cv < 0) ? 8'($urandom_range(0, 255)) : 8'(cv);
            sum += longint'(x) * longint'(c);
            send_pair(x, c, use_last && (i == n - 1));
        end
        if (push) sbq.push_back(model(sum, n, !use_last));
    endtask

    // Waits for the result while presenting junk input that must be ignored,
    // optionally stalls out_ready for 'hold' cycles, then completes the
    // handshake and checks that in_ready returns the next cycle.
    task automatic finish_frame(input int hold);
        int g;
        logic [34:0] snap;
        g = 0;
        bus.out_ready = (hold == 0);
        bus.in_valid  = 1'b1;
        bus.in_x      = 8'($urandom_range(0, 255));
        bus.in_c      = 8'($urandom_range(0, 255));
        bus.in_last   = 1'b1;
        @(negedge clk);
        while (!bus.out_valid && g < 60) begin
            g++;
            @(negedge clk);
        end
        chk("result_seen", 64'(bus.out_valid), 64'd1);
        if (hold > 0) begin
            snap = {bus.xncn, bus.onebyn, bus.sat, bus.frame_ovf};
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("hold_stable",
                    64'({bus.out_valid, bus.in_ready, bus.xncn, bus.onebyn, bus.sat, bus.frame_ovf}),
                    64'({1'b1, 1'b0, snap}));
            end
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        @(negedge clk);
        chk("ready_after_hs", 64'({bus.in_ready, bus.out_valid}), 64'd2);
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_c      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_xncn",      64'(bus.xncn),      64'd0);
        chk("rst_onebyn",    64'(bus.onebyn),    64'd0);
        chk("rst_sat",       64'(bus.sat),       64'd0);
        chk("rst_frame_ovf", 64'(bus.frame_ovf), 64'd0);
        @(posedge clk);
        #1;

        run_frame(4, 10, 20, 1'b1, 1'b0, 1'b1);     finish_frame(0);
        run_frame(1, 255, 255, 1'b1, 1'b0, 1'b1);   finish_frame(1);
        run_frame(2, 255, 255, 1'b1, 1'b0, 1'b1);   finish_frame(2);
        run_frame(4, 7, 9, 1'b1, 1'b0, 1'b1);       finish_frame(5);
        run_frame(3, 1, 1, 1'b1, 1'b0, 1'b1);       finish_frame(0);

        // Reset mid-division: nothing may be emitted, outputs clear.
        run_frame(3, 9, 9, 1'b1, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_outputs",
            64'({bus.xncn, bus.onebyn, bus.sat, bus.frame_ovf}), 64'd0);
        bus.out_ready = 1'b1;
        repeat (25) @(negedge clk);
        chk("midrst_no_result", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        run_frame(2, 2, 3, 1'b1, 1'b0, 1'b1);       finish_frame(0);

        run_frame(6, 1, 1, 1'b1, 1'b0, 1'b1);       finish_frame(1);
        run_frame(1023, 1, 1, 1'b0, 1'b0, 1'b1);    finish_frame(3);

        for (int f = 0; f < 25; f++) begin
            run_frame($urandom_range(1, 40), -1, -1, 1'b1, 1'b1, 1'b1);
            finish_frame($urandom_range(0, 3));
        end

        repeat (5) @(negedge clk);
        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
